// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path:
// segment patterns, digit positions and field selects.
package stopwatch_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0    = 7'b1000000;
   localparam seg_t SEG_1    = 7'b1111001;
   localparam seg_t SEG_2    = 7'b0100100;
   localparam seg_t SEG_3    = 7'b0110000;
   localparam seg_t SEG_4    = 7'b0011001;
   localparam seg_t SEG_5    = 7'b0010010;
   localparam seg_t SEG_6    = 7'b0000010;
   localparam seg_t SEG_7    = 7'b1111000;
   localparam seg_t SEG_8    = 7'b0000000;
   localparam seg_t SEG_9    = 7'b0010000;
   localparam seg_t SEG_DASH = 7'b0111111;
   localparam seg_t SEG_OFF  = 7'b1111111;

   localparam logic [1:0] DIG_SEC_ONES = 2'd0;
   localparam logic [1:0] DIG_SEC_TENS = 2'd1;
   localparam logic [1:0] DIG_MIN_ONES = 2'd2;
   localparam logic [1:0] DIG_MIN_TENS = 2'd3;

   localparam logic SEL_MIN = 1'b0;
   localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern.
// Codes above 9 render as a dash.
module bcd_to_seg
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // decode one digit, dash as the fallback
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver with
// per-frame snapshot, ghost guard and field blinking.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_ones,
   input  logic       adj,
   input  logic       sel,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

   logic [RW-1:0]     refresh_cnt;
   logic [1:0]        idx;
   logic [BW-1:0]     blink_cnt;
   logic              phase;
   logic [3:0][3:0]   snap;
   logic [3:0]        digit;
   logic [6:0]        dec_seg;
   logic              sel_hit;
   logic              blank;
   logic [3:0]        an_next;

   assign digit = snap[idx];

   bcd_to_seg u_dec (
      .bcd (digit),
      .seg (dec_seg)
   );

   // slot counter and digit index scan
   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt <= '0;
         idx         <= DIG_SEC_ONES;
      end else if (refresh_cnt == R_LAST) begin
         refresh_cnt <= '0;
         idx         <= idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // capture all digits once per frame
   always_ff @(posedge clk) begin
      if (reset) begin
         snap <= '0;
      end else if (idx == DIG_SEC_ONES && refresh_cnt == '0) begin
         snap <= {min_tens, min_ones, sec_tens, sec_ones};
      end
   end

   // blink timer runs only while adjusting
   always_ff @(posedge clk) begin
      if (reset || !adj) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == B_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // pick the anode, honouring ghost guard and blink
   always_comb begin
      sel_hit = (sel == SEL_SEC) ? (idx <= DIG_SEC_TENS)
                                 : (idx >= DIG_MIN_ONES);
      blank   = adj & phase & sel_hit;
      an_next = 4'b1111;
      if (refresh_cnt != '0 && !blank)
         an_next[idx] = 1'b0;
   end

   // registered pin drivers
   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= SEG_OFF;
         dp  <= 1'b1;
         an  <= 4'b1111;
      end else begin
         seg <= dec_seg;
         dp  <= (idx != DIG_MIN_ONES);
         an  <= an_next;
      end
   end

endmodule
